// File: rtl/idecode_stage_pkg.sv
// idecode_stage_pkg: shared widths, opcode constants, ALUOp encodings and the
// main-control bundle used by the decode stage and its register file.
// ctrl bundle packs as {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead,
// MemWrite, Branch, ALUOp[1:0]}; bit-index constants below match that order.
package idecode_stage_pkg;

    localparam int WORD_W  = 32;
    localparam int RADDR_W = 5;
    localparam int NREGS_N = 32;
    localparam int CTRL_W  = 9;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam int CB_REGDST   = 8;
    localparam int CB_ALUSRC   = 7;
    localparam int CB_MEMTOREG = 6;
    localparam int CB_REGWRITE = 5;
    localparam int CB_MEMREAD  = 4;
    localparam int CB_MEMWRITE = 3;
    localparam int CB_BRANCH   = 2;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/idecode_stage_regfile.sv
// idecode_stage_regfile: 2-read / 1-write general-purpose register file.
//   clk, reset            : clock, asynchronous active-high reset (clears all)
//   raddr1/raddr2, rdata* : combinational read ports
//   we, waddr, wdata      : synchronous write port
// Register 0 always reads 0 and ignores writes.
// Optional macro WB_BYPASS_EN: a read whose index matches a write in the same
// cycle returns the write data instead of the stored value.
module idecode_stage_regfile
    import idecode_stage_pkg::*;
#(
    parameter int WORD  = WORD_W,
    parameter int RADDR = RADDR_W,
    parameter int NREGS = NREGS_N
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RADDR-1:0] raddr1,
    input  logic [RADDR-1:0] raddr2,
    output logic [WORD-1:0]  rdata1,
    output logic [WORD-1:0]  rdata2,
    input  logic             we,
    input  logic [RADDR-1:0] waddr,
    input  logic [WORD-1:0]  wdata
);

    logic [WORD-1:0] regs_q [NREGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (we && waddr != '0) begin
            regs_q[waddr] <= wdata;
        end
    end

    function automatic logic [WORD-1:0] rd(input logic [RADDR-1:0] a);
        if (a == '0) return '0;
`ifdef WB_BYPASS_EN
        if (we && a == waddr) return wdata;
`endif
        return regs_q[a];
    endfunction

    assign rdata1 = rd(raddr1);
    assign rdata2 = rd(raddr2);

endmodule

// File: rtl/idecode_stage.sv
// idecode_stage: instruction decode + ID/EX pipeline register.
//   clk, reset               : clock, asynchronous active-high reset
//   nPC, IR, if_valid        : fetched instruction from IF
//   stall, flush             : ID/EX hold / bubble insert (flush wins)
//   wb_we, wb_addr, wb_data  : register-file write port from WB
//   ex_*                     : ID/EX register contents
// Optional macro WB_BYPASS_EN (handled in the register file): forward a
// same-cycle WB write to the operand reads.
module idecode_stage
    import idecode_stage_pkg::*;
#(
    parameter int WORD  = WORD_W,
    parameter int RADDR = RADDR_W,
    parameter int NREGS = NREGS_N
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD-1:0]   nPC,
    input  logic [WORD-1:0]   IR,
    input  logic              if_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [RADDR-1:0]  wb_addr,
    input  logic [WORD-1:0]   wb_data,
    output logic              ex_valid,
    output logic [WORD-1:0]   ex_npc,
    output logic [WORD-1:0]   ex_rdata1,
    output logic [WORD-1:0]   ex_rdata2,
    output logic [WORD-1:0]   ex_imm,
    output logic [RADDR-1:0]  ex_rt,
    output logic [RADDR-1:0]  ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_illegal
);

    logic [WORD-1:0] rdata1, rdata2;
    ctrl_t           ctrl_d;
    logic            illegal_d;

    idecode_stage_regfile #(.WORD(WORD), .RADDR(RADDR), .NREGS(NREGS)) u_rf (
        .clk    (clk),
        .reset  (reset),
        .raddr1 (IR[25:21]),
        .raddr2 (IR[20:16]),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .we     (wb_we),
        .waddr  (wb_addr),
        .wdata  (wb_data)
    );

    // Main control. An invalid fetch slot decodes as a bubble so it can never
    // write a register, write memory or branch.
    always_comb begin
        ctrl_d    = '0;
        illegal_d = 1'b0;
        case (IR[31:26])
            OP_RTYPE: begin
                ctrl_d.reg_dst   = 1'b1;
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_op    = ALUOP_FUNCT;
            end
            OP_LW: begin
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_read   = 1'b1;
                ctrl_d.alu_op     = ALUOP_ADD;
            end
            OP_SW: begin
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.mem_write = 1'b1;
                ctrl_d.alu_op    = ALUOP_ADD;
            end
            OP_BEQ: begin
                ctrl_d.branch = 1'b1;
                ctrl_d.alu_op = ALUOP_SUB;
            end
            OP_ADDI: begin
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_op    = ALUOP_ADD;
            end
            default: illegal_d = 1'b1;
        endcase
        if (!if_valid) begin
            ctrl_d    = '0;
            illegal_d = 1'b0;
        end
    end

    logic              valid_q, illegal_q;
    logic [WORD-1:0]   npc_q, rdata1_q, rdata2_q, imm_q;
    logic [RADDR-1:0]  rt_q, rd_q;
    logic [CTRL_W-1:0] ctrl_q;

    // Flush clears only the qualifying bits; data fields simply hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            npc_q     <= '0;
            rdata1_q  <= '0;
            rdata2_q  <= '0;
            imm_q     <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            ctrl_q    <= '0;
        end else if (flush) begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            ctrl_q    <= '0;
        end else if (!stall) begin
            valid_q   <= if_valid;
            illegal_q <= illegal_d;
            npc_q     <= nPC;
            rdata1_q  <= rdata1;
            rdata2_q  <= rdata2;
            imm_q     <= {{(WORD-16){IR[15]}}, IR[15:0]};
            rt_q      <= IR[20:16];
            rd_q      <= IR[15:11];
            ctrl_q    <= ctrl_d;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_illegal = illegal_q;
    assign ex_npc     = npc_q;
    assign ex_rdata1  = rdata1_q;
    assign ex_rdata2  = rdata2_q;
    assign ex_imm     = imm_q;
    assign ex_rt      = rt_q;
    assign ex_rd      = rd_q;
    assign ex_ctrl    = ctrl_q;

endmodule

// File: tb/tb_idecode_stage.sv
module tb_idecode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] nPC, IR, wb_data;
    logic        if_valid, stall, flush, wb_we;
    logic [4:0]  wb_addr;
    logic        ex_valid, ex_illegal;
    logic [31:0] ex_npc, ex_rdata1, ex_rdata2, ex_imm;
    logic [4:0]  ex_rt, ex_rd;
    logic [8:0]  ex_ctrl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    idecode_stage dut (
        .clk(clk), .reset(reset), .nPC(nPC), .IR(IR), .if_valid(if_valid),
        .stall(stall), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data), .ex_valid(ex_valid), .ex_npc(ex_npc),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
        .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
        .ex_illegal(ex_illegal)
    );

    // Reference model: architectural register array plus expected ID/EX.
    logic [31:0] mregs [32];
    logic        e_valid, e_ill;
    logic [31:0] e_npc, e_r1, e_r2, e_imm;
    logic [4:0]  e_rt, e_rd;
    logic [8:0]  e_ctrl;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
        if (wb_we && wb_addr == a) return wb_data;
`endif
        return mregs[a];
    endfunction

    // Control as a table of named fields per instruction class.
    function automatic void model_decode(input logic [5:0] op,
                                         output logic [8:0] c, output logic ill);
        logic regdst, alusrc, m2r, regw, memr, memw, br;
        logic [1:0] aluop;
        {regdst, alusrc, m2r, regw, memr, memw, br, aluop} = '0;
        ill = 1'b0;
        if (op == 6'd0) begin regdst = 1; regw = 1; aluop = 2'b10; end
        else if (op == 6'd35) begin alusrc = 1; m2r = 1; regw = 1; memr = 1; end
        else if (op == 6'd43) begin alusrc = 1; memw = 1; end
        else if (op == 6'd4) begin br = 1; aluop = 2'b01; end
        else if (op == 6'd8) begin alusrc = 1; regw = 1; end
        else ill = 1'b1;
        c = {regdst, alusrc, m2r, regw, memr, memw, br, aluop};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        {e_valid, e_ill, e_npc, e_r1, e_r2, e_imm, e_rt, e_rd, e_ctrl} = '0;
    endtask

    task automatic model_edge();
        logic [8:0] c;
        logic       il;
        if (reset) begin
            model_clear();
            return;
        end
        if (flush) begin
            e_valid = 0; e_ctrl = '0; e_ill = 0;
        end else if (!stall) begin
            model_decode(IR[31:26], c, il);
            e_valid = if_valid;
            e_ctrl  = if_valid ? c : 9'h0;
            e_ill   = if_valid ? il : 1'b0;
            e_npc   = nPC;
            e_r1    = model_read(IR[25:21]);
            e_r2    = model_read(IR[20:16]);
            e_imm   = {{16{IR[15]}}, IR[15:0]};
            e_rt    = IR[20:16];
            e_rd    = IR[15:11];
        end
        if (wb_we && wb_addr != 5'd0) mregs[wb_addr] = wb_data;
    endtask

    task automatic compare_all();
        check("ex_valid", {31'h0, ex_valid}, {31'h0, e_valid});
        check("ex_illegal", {31'h0, ex_illegal}, {31'h0, e_ill});
        check("ex_ctrl", {23'h0, ex_ctrl}, {23'h0, e_ctrl});
        check("ex_npc", ex_npc, e_npc);
        check("ex_rdata1", ex_rdata1, e_r1);
        check("ex_rdata2", ex_rdata2, e_r2);
        check("ex_imm", ex_imm, e_imm);
        check("ex_rt", {27'h0, ex_rt}, {27'h0, e_rt});
        check("ex_rd", {27'h0, ex_rd}, {27'h0, e_rd});
    endtask

    // Inputs are driven at negedge; one step = edge + model + compare.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input logic [31:0] ir, input logic [31:0] npc,
                         input logic v, input logic st, input logic fl,
                         input logic we, input logic [4:0] wa,
                         input logic [31:0] wd);
        IR = ir; nPC = npc; if_valid = v; stall = st; flush = fl;
        wb_we = we; wb_addr = wa; wb_data = wd;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, {31'h0, ex_valid}, 32'h0);
        check({tag, "_illegal"}, {31'h0, ex_illegal}, 32'h0);
        check({tag, "_ctrl"}, {23'h0, ex_ctrl}, 32'h0);
        check({tag, "_npc"}, ex_npc, 32'h0);
        check({tag, "_rdata1"}, ex_rdata1, 32'h0);
        check({tag, "_rdata2"}, ex_rdata2, 32'h0);
        check({tag, "_imm"}, ex_imm, 32'h0);
        check({tag, "_rt_rd"}, {22'h0, ex_rt, ex_rd}, 32'h0);
    endtask

    // Asynchronous reset mid low-phase: outputs must clear before any edge.
    task automatic mid_reset();
        #2 reset = 1'b1;
        #1 check_all_zero("async_rst");
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [5:0] ops [6];

    initial begin
        ops[0] = 6'd0; ops[1] = 6'd35; ops[2] = 6'd43;
        ops[3] = 6'd4; ops[4] = 6'd8;  ops[5] = 6'd0;
        reset = 1'b1;
        drive(32'h0, 32'h0, 0, 0, 0, 0, 5'd0, 32'h0);
        model_clear();
        #1 check_all_zero("por");
        @(negedge clk);
        reset = 1'b0;

        // add r3,r1,r2 with r1=AA, r2=55
        drive(32'h0, 32'h0, 0, 0, 0, 1, 5'd1, 32'hAA); step();
        drive(32'h0, 32'h0, 0, 0, 0, 1, 5'd2, 32'h55); step();
        drive(32'h0022_1820, 32'd4, 1, 0, 0, 0, 5'd0, 32'h0); step();
        check("add_r1", ex_rdata1, 32'hAA);
        check("add_r2", ex_rdata2, 32'h55);
        check("add_rd", {27'h0, ex_rd}, 32'd3);
        check("add_ctrl", {23'h0, ex_ctrl}, 32'h122);
        check("add_npc", ex_npc, 32'd4);

        // lw r2,-4(r1)
        drive(32'h8C22_FFFC, 32'd8, 1, 0, 0, 0, 5'd0, 32'h0); step();
        check("lw_imm", ex_imm, 32'hFFFF_FFFC);
        check("lw_ctrl", {23'h0, ex_ctrl}, 32'h0F0);
        check("lw_rt", {27'h0, ex_rt}, 32'd2);

        // flush + stall on beq, then stall alone
        drive(32'h1022_0003, 32'd12, 1, 1, 1, 0, 5'd0, 32'h0); step();
        check("flush_valid", {31'h0, ex_valid}, 32'h0);
        check("flush_ctrl", {23'h0, ex_ctrl}, 32'h0);
        drive(32'h1022_0003, 32'd12, 1, 1, 0, 0, 5'd0, 32'h0); step();
        check("stall_valid", {31'h0, ex_valid}, 32'h0);
        check("stall_imm", ex_imm, 32'hFFFF_FFFC);

        // write to r0 discarded
        drive(32'h0, 32'h0, 0, 0, 0, 1, 5'd0, 32'hDEAD_BEEF); step();
        drive(32'h0000_0020, 32'd16, 1, 0, 0, 0, 5'd0, 32'h0); step();
        check("r0_read", ex_rdata1, 32'h0);

        // same-cycle write and read of r1
        drive(32'h0022_0820, 32'd20, 1, 0, 0, 1, 5'd1, 32'h1234); step();
`ifdef WB_BYPASS_EN
        check("same_cyc_r1", ex_rdata1, 32'h1234);
`else
        check("same_cyc_r1", ex_rdata1, 32'hAA);
`endif
        drive(32'h0020_0000, 32'd24, 1, 0, 0, 0, 5'd0, 32'h0); step();
        check("r1_after_wr", ex_rdata1, 32'h1234);

        // unknown opcode
        drive(32'hFC00_0000, 32'd28, 1, 0, 0, 0, 5'd0, 32'h0); step();
        check("ill_flag", {31'h0, ex_illegal}, 32'h1);
        check("ill_ctrl", {23'h0, ex_ctrl}, 32'h0);

        // reset mid-run with nonzero ID/EX, then registers read back as 0
        drive(32'h0022_1820, 32'd32, 1, 0, 0, 0, 5'd0, 32'h0); step();
        mid_reset();
        drive(32'h0022_1820, 32'd36, 1, 0, 0, 0, 5'd0, 32'h0); step();
        check("post_rst_r1", ex_rdata1, 32'h0);
        check("post_rst_r2", ex_rdata2, 32'h0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ir;
            logic [5:0]  op;
            int          k;
            k  = $urandom_range(0, 6);
            op = (k == 6) ? 6'($urandom) : ops[k];
            ir = $urandom;
            ir[31:26] = op;
            drive(ir, $urandom, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 6) == 0, $urandom_range(0, 8) == 0,
                  $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)),
                  $urandom);
            if ($urandom_range(0, 149) == 0) mid_reset();
            else step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/idecode_stage.md
Name: idecode_stage

Overview:
- Instruction-decode stage directly downstream of the fetch stage.
- Consumes the fetched instruction (IR) and incremented PC (nPC); contains the 32-entry register file.
- Each cycle it reads two operands, sign-extends the immediate and generates main control.
- Captures all of this in the ID/EX pipeline register, with stall, flush and writeback-port handling.

Parameters:
- WORD, 32, datapath width; matches `WORD.
- RADDR, 5, register-address width.
- NREGS, 32, number of architectural registers.

Ports:
- clk  in  1  system clock, rising edge active
- reset  in  1  asynchronous, active-high reset
- nPC  in  WORD  PC+4 from fetch
- IR  in  WORD  instruction from fetch
- if_valid  in  1  IR/nPC hold a real instruction
- stall  in  1  freeze ID/EX contents
- flush  in  1  load a bubble into ID/EX
- wb_we  in  1  register-file write enable from WB
- wb_addr  in  RADDR  write register
- wb_data  in  WORD  write data
- ex_valid  out  1  ID/EX holds a real instruction
- ex_npc  out  WORD  latched nPC
- ex_rdata1  out  WORD  GPR[rs]
- ex_rdata2  out  WORD  GPR[rt]
- ex_imm  out  WORD  sign-extended IR[15:0]
- ex_rt  out  RADDR  IR[20:16]
- ex_rd  out  RADDR  IR[15:11]
- ex_ctrl  out  9  {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0]}
- ex_illegal  out  1  unrecognised opcode latched

Behaviour:
- Reset (asynchronous, immediate, independent of clk):
  - All ID/EX outputs go to 0.
  - All NREGS registers clear to 0.
- Latency: one cycle. Fields decoded from IR combinationally; the rising edge after presentation loads ID/EX.
- Register file:
  - Two combinational read ports, indexed by IR[25:21] and IR[20:16].
  - One synchronous write port, written at posedge when wb_we=1.
  - Register 0 reads 0 always; writes to it are discarded.
  - wb_we is honoured during stall and flush.
- Same-cycle write to a register being read, without the feature: the read returns the pre-write value.
- Sign extension: ex_imm = {16{IR[15]}, IR[15:0]}.
- Control decode, by opcode IR[31:26]:
  - 000000 R-type: RegDst=1, RegWrite=1, ALUOp=10.
  - 100011 lw: ALUSrc=1, MemtoReg=1, RegWrite=1, MemRead=1, ALUOp=00.
  - 101011 sw: ALUSrc=1, MemWrite=1, ALUOp=00.
  - 000100 beq: Branch=1, ALUOp=01.
  - 001000 addi: ALUSrc=1, RegWrite=1, ALUOp=00.
  - Any other opcode: ctrl=0 and ex_illegal=1. ex_valid still follows if_valid.
- ID/EX update priority at posedge: flush > stall > normal load.
  - flush=1: ex_valid=0, ex_ctrl=0, ex_illegal=0; data fields don't-care (hold).
  - stall=1 (flush=0): all ID/EX outputs hold.
  - Otherwise: load decoded values; ex_valid=if_valid.
  - if_valid=0: ctrl and ex_illegal forced to 0 (bubble).
- A bubble never has RegWrite, MemWrite or Branch asserted.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - Read data is forwarded when wb_we=1, wb_addr!=0 and wb_addr matches the read index.
  - The forwarded value is wb_data, so ID/EX captures the new value in the same edge as the register-file write.
  - Applies independently to each port.
- Undefined: the old value is captured, and the compiler/hazard logic must insert a bubble.

Decomposition:
- definitions.vh (shared): `WORD, `CYCLE, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI), ALUOp encodings, ctrl bit-index constants.
- Sub-module regfile: 2R/1W, async reset, zero register, bypass under WB_BYPASS_EN.
- Decode logic and the ID/EX register stay in idecode_stage.

Test Plan:
- Assert reset mid-run with nonzero ID/EX -> all outputs 0 immediately, before the next clk edge; later reads of any register return 0.
- Write 0x0000_00AA to r1 and 0x0000_0055 to r2 via WB. Present IR=0x0022_1820 (add r3,r1,r2), nPC=4, if_valid=1. Next edge -> ex_rdata1=0xAA, ex_rdata2=0x55, ex_rd=3, RegDst=1, RegWrite=1, ALUOp=10, ex_npc=4.
- IR=0x8C22_FFFC (lw r2,-4(r1)) -> ex_imm=0xFFFF_FFFC, ALUSrc=1, MemRead=1, MemtoReg=1, ex_rt=2.
- flush=1 and stall=1 together on a valid beq -> ex_valid=0, ex_ctrl=0. Next cycle, stall only -> outputs unchanged.
- wb_we=1, wb_addr=0, wb_data=0xDEAD_BEEF, then read r0 -> 0.
- Same-cycle WB write of 0x1234 to r1 while IR reads r1 -> ex_rdata1=0x1234 with WB_BYPASS_EN, else the old value. Opcode 0x3F -> ex_illegal=1, ctrl=0.
